// File: rtl/rect_poll_ctrl.sv
// Round-robin poll scheduler for rectifier units that share one serial receiver.
// It selects a channel, fires a query, waits for a frame or a timeout, then publishes the result.
module rect_poll_ctrl #(
   parameter int          N_CH        = 4,
   parameter int          CH_W        = 2,
   parameter logic [15:0] SETTLE_CYC  = 16'd2222,
   parameter logic [19:0] TIMEOUT_CYC = 20'd200000,
   parameter logic [15:0] GAP_CYC     = 16'd11111,
   parameter int          MAX_RETRY   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            poll_en,
   input  logic [N_CH-1:0] ch_mask,
   input  logic            rx_en,
   input  logic [19:0]     rx_data,
   output logic [CH_W-1:0] rx_sel,
   output logic            qry_start,
   output logic [CH_W-1:0] qry_ch,
   output logic            busy,
   output logic            upd_en,
   output logic [CH_W-1:0] upd_ch,
   output logic [19:0]     upd_data,
   output logic [N_CH-1:0] ch_fault
);

   localparam int RETRY_W = $clog2(MAX_RETRY + 1);

   typedef enum logic [2:0] {IDLE, SEL, QUERY, WAIT, GAP} state_t;

   state_t               state;
   logic [CH_W-1:0]      ch_ptr;
   logic [CH_W-1:0]      next_ch;
   logic [RETRY_W-1:0]   retry;
   logic [15:0]          cnt;
   logic [19:0]          tmo_cnt;

   function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
      return (c == CH_W'(N_CH - 1)) ? '0 : c + CH_W'(1);
   endfunction

   // First masked-in channel at or after ch_ptr, wrapping at N_CH-1.
   always_comb begin
      logic [CH_W-1:0] scan;
      logic            found;
      next_ch = ch_ptr;
      found   = 1'b0;
      scan    = ch_ptr;
      for (int i = 0; i < N_CH; i++) begin
         if (!found && ch_mask[scan]) begin
            next_ch = scan;
            found   = 1'b1;
         end
         scan = ch_inc(scan);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rx_sel    <= '0;
         qry_start <= 1'b0;
         qry_ch    <= '0;
         busy      <= 1'b0;
         upd_en    <= 1'b0;
         upd_ch    <= '0;
         upd_data  <= '0;
         ch_fault  <= '0;
         ch_ptr    <= '0;
         retry     <= '0;
         cnt       <= '0;
         tmo_cnt   <= '0;
      end else begin
         qry_start <= 1'b0;
         upd_en    <= 1'b0;
         case (state)
            IDLE: begin
               if (poll_en && |ch_mask) begin
                  rx_sel <= next_ch;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= SEL;
               end
            end
            SEL: begin
               if (cnt == SETTLE_CYC - 16'd1) begin
                  cnt       <= '0;
                  qry_start <= 1'b1;
                  qry_ch    <= rx_sel;
                  state     <= QUERY;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            QUERY: begin
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               // A frame arriving on the timeout cycle still counts as an answer.
               if (rx_en) begin
                  upd_en           <= 1'b1;
                  upd_ch           <= rx_sel;
                  upd_data         <= rx_data;
                  ch_fault[rx_sel] <= 1'b0;
                  retry            <= '0;
                  ch_ptr           <= ch_inc(rx_sel);
                  cnt              <= '0;
                  state            <= GAP;
               end else if (tmo_cnt == TIMEOUT_CYC - 20'd1) begin
                  if (retry < RETRY_W'(MAX_RETRY)) begin
                     retry <= retry + RETRY_W'(1);
                  end else begin
                     ch_fault[rx_sel] <= 1'b1;
                     retry            <= '0;
                     ch_ptr           <= ch_inc(rx_sel);
                  end
                  cnt   <= '0;
                  state <= GAP;
               end else begin
                  tmo_cnt <= tmo_cnt + 20'd1;
               end
            end
            GAP: begin
               if (cnt == GAP_CYC - 16'd1) begin
                  cnt <= '0;
                  if (poll_en && |ch_mask) begin
                     state <= SEL;
                     // A pending retry sticks to its channel only while it stays masked in.
                     if (retry == '0 || !ch_mask[rx_sel]) begin
                        retry  <= '0;
                        rx_sel <= next_ch;
                     end
                  end else begin
                     retry <= '0;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rect_poll_ctrl.sv
// Randomized bench for rect_poll_ctrl against a transaction-level model of the poll schedule.
// cyc counts rising edges since rst was released; query timing is predicted from that count.
module tb_rect_poll_ctrl;
   localparam int N_CH      = 4;
   localparam int CH_W      = 2;
   localparam int SETTLE    = 4;
   localparam int TIMEOUT   = 100;
   localparam int GAP       = 10;
   localparam int MAX_RETRY = 2;

   logic            clk     = 1'b0;
   logic            rst     = 1'b1;
   logic            poll_en = 1'b0;
   logic [N_CH-1:0] ch_mask = '0;
   logic            rx_en   = 1'b0;
   logic [19:0]     rx_data = '0;
   logic [CH_W-1:0] rx_sel;
   logic            qry_start;
   logic [CH_W-1:0] qry_ch;
   logic            busy;
   logic            upd_en;
   logic [CH_W-1:0] upd_ch;
   logic [19:0]     upd_data;
   logic [N_CH-1:0] ch_fault;

   rect_poll_ctrl #(
      .N_CH(N_CH), .CH_W(CH_W), .SETTLE_CYC(16'(SETTLE)), .TIMEOUT_CYC(20'(TIMEOUT)),
      .GAP_CYC(16'(GAP)), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .rst(rst), .poll_en(poll_en), .ch_mask(ch_mask), .rx_en(rx_en),
      .rx_data(rx_data), .rx_sel(rx_sel), .qry_start(qry_start), .qry_ch(qry_ch),
      .busy(busy), .upd_en(upd_en), .upd_ch(upd_ch), .upd_data(upd_data), .ch_fault(ch_fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_upd = 0;
   int n_qry = 0;
   always @(posedge clk) begin
      cyc <= rst ? 0 : cyc + 1;
      if (upd_en) n_upd <= n_upd + 1;
      if (qry_start) n_qry <= n_qry + 1;
   end

   int n_chk = 0;
   int n_err = 0;
   logic [N_CH-1:0] m_fault = '0;
   logic [N_CH-1:0] dead = '0;
   int m_ptr = 0, m_retry = 0, cur = 0, tq = 0;
   int exp_upd = 0, exp_qry = 0, ch2_tries = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int pick(input int p, input logic [N_CH-1:0] m);
      for (int i = 0; i < N_CH; i++)
         if (m[(p + i) % N_CH]) return (p + i) % N_CH;
      return -1;
   endfunction

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_qry(input int exp_t, input int exp_ch);
      while (!qry_start && cyc < exp_t + 3) @(negedge clk);
      chk("qry_seen", qry_start, 1);
      chk("qry_time", cyc, exp_t);
      chk("qry_ch", qry_ch, exp_ch);
      chk("rx_sel", rx_sel, exp_ch);
      if (qry_start && qry_ch == 2'd2) ch2_tries++;
      exp_qry++;
      cur = exp_ch;
      tq  = cyc;
   endtask

   // One poll attempt starting at the negedge where qry_start was seen.
   task automatic attempt(input bit ans, input int d, input logic [19:0] dat, input bit early,
                          input bit spur, input bit new_poll, input logic [N_CH-1:0] new_mask);
      int e;
      int nch;
      if (early) begin
         wait_until(tq + 2);
         poll_en = new_poll;
         ch_mask = new_mask;
      end
      if (ans) begin
         wait_until(tq + d);
         rx_en   = 1'b1;
         rx_data = dat;
         @(negedge clk);
         rx_en = 1'b0;
         e = tq + d + 1;
         chk("upd_en", upd_en, 1);
         chk("upd_ch", upd_ch, cur);
         chk("upd_data", upd_data, dat);
         exp_upd++;
         m_fault[cur] = 1'b0;
         m_retry      = 0;
         m_ptr        = (cur + 1) % N_CH;
      end else begin
         e = tq + TIMEOUT + 1;
         wait_until(e);
         chk("upd_en_tmo", upd_en, 0);
         if (m_retry < MAX_RETRY) m_retry++;
         else begin
            m_fault[cur] = 1'b1;
            m_retry      = 0;
            m_ptr        = (cur + 1) % N_CH;
         end
      end
      chk("ch_fault", ch_fault, m_fault);
      chk("busy_gap", busy, 1);
      @(negedge clk);
      chk("upd_count", n_upd, exp_upd);
      chk("qry_count", n_qry, exp_qry);
      if (!early) begin
         poll_en = new_poll;
         ch_mask = new_mask;
      end
      if (spur) rx_en = 1'b1;
      @(negedge clk);
      rx_en = 1'b0;
      if (poll_en && ch_mask != '0) begin
         if (m_retry > 0 && ch_mask[cur]) nch = cur;
         else begin
            m_retry = 0;
            nch     = pick(m_ptr, ch_mask);
         end
         if (spur) begin
            wait_until(e + GAP + 1);
            rx_en = 1'b1;
            @(negedge clk);
            rx_en = 1'b0;
         end
         wait_qry(e + GAP + SETTLE, nch);
      end else begin
         m_retry = 0;
         wait_until(e + GAP);
         chk("busy_idle", busy, 0);
         repeat (20) @(negedge clk);
         chk("idle_no_qry", n_qry, exp_qry);
         chk("idle_busy", busy, 0);
         chk("idle_upd_count", n_upd, exp_upd);
      end
   endtask

   task automatic resume(input logic [N_CH-1:0] m);
      poll_en = 1'b1;
      ch_mask = m;
      wait_qry(cyc + 1 + SETTLE, pick(m_ptr, m));
   endtask

   task automatic run_rand(input bit mask_chg);
      bit              ans;
      int              d;
      logic [N_CH-1:0] nm;
      ans = !dead[cur] && ($urandom_range(0, 7) != 0);
      d   = ($urandom_range(0, 5) == 0) ? TIMEOUT : $urandom_range(1, TIMEOUT - 1);
      nm  = ch_mask;
      if (mask_chg && $urandom_range(0, 5) == 0) nm = 4'($urandom_range(1, 15));
      attempt(ans, d, 20'($urandom), 1'b0, $urandom_range(0, 3) == 0, poll_en, nm);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_rx_sel"}, rx_sel, 0);
      chk({tag, "_qry_start"}, qry_start, 0);
      chk({tag, "_qry_ch"}, qry_ch, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_upd_en"}, upd_en, 0);
      chk({tag, "_upd_ch"}, upd_ch, 0);
      chk({tag, "_upd_data"}, upd_data, 0);
      chk({tag, "_ch_fault"}, ch_fault, 0);
   endtask

   initial begin
      rst     = 1'b1;
      poll_en = 1'b1;
      ch_mask = 4'hF;
      repeat (3) @(negedge clk);
      chk_zero_outputs("rst");
      rst = 1'b0;
      wait_qry(SETTLE + 1, 0);

      // First answer 20 cycles into the poll; the following query goes to ch1.
      attempt(1'b1, 20, 20'hA1234, 1'b0, 1'b0, 1'b1, 4'hF);

      // Ch2 stays silent until its fault bit is set.
      dead = 4'b0100;
      ch2_tries = 0;
      for (int i = 0; i < 20 && !m_fault[2]; i++) run_rand(1'b0);
      chk("ch2_tries", ch2_tries, 3);
      chk("ch2_fault", ch_fault, 4'b0100);
      dead = '0;
      for (int i = 0; i < 20 && m_fault[2]; i++) run_rand(1'b0);
      chk("ch2_cleared", ch_fault[2], 0);

      // Sparse mask alternates between ch0 and ch3.
      attempt(1'b1, 7, 20'h13579, 1'b0, 1'b0, 1'b1, 4'b1001);
      for (int i = 0; i < 5; i++) begin
         chk("m1001_ch", (qry_ch == 2'd0 || qry_ch == 2'd3), 1);
         attempt(1'b1, $urandom_range(1, TIMEOUT - 1), 20'($urandom), 1'b0, 1'b1, 1'b1, 4'b1001);
      end
      attempt(1'b1, 10, 20'h2468A, 1'b0, 1'b0, 1'b1, 4'b0000);
      resume(4'hF);

      // Answer on the exact timeout cycle.
      attempt(1'b1, TIMEOUT, 20'h5A5A5, 1'b0, 1'b0, 1'b1, 4'hF);

      dead = 4'b1000;
      for (int i = 0; i < 40; i++) run_rand(1'b1);
      dead = '0;

      // poll_en dropped while waiting: attempt completes, then idle.
      attempt(1'b1, 30, 20'hC0FFE, 1'b1, 1'b0, 1'b0, ch_mask);
      resume(4'hF);
      for (int i = 0; i < 4; i++) run_rand(1'b0);

      // Reset in the middle of WAIT.
      dead = 4'b0001;
      for (int i = 0; i < 12 && !m_fault[0]; i++) run_rand(1'b0);
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_zero_outputs("midrst");
      m_fault = '0;
      m_ptr   = 0;
      m_retry = 0;
      dead    = '0;
      rst     = 1'b0;
      wait_qry(SETTLE + 1, pick(0, ch_mask));
      attempt(1'b1, 5, 20'h0BEEF, 1'b0, 1'b0, 1'b1, ch_mask);
      @(negedge clk);
      chk("final_upd_count", n_upd, exp_upd);
      chk("final_qry_count", n_qry, exp_qry);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion (cyc %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
